// File: rtl/rapcore_spi_controller.sv
`timescale 1ns/1ps
// Wishbone-slave SPI initiator (mode 0, MSB first, 32-bit words) for rapcore bring-up.
// Optional feature: define RAPCORE_SPI_LOOPBACK_EN to implement CTRL.LOOPBACK (COPI fed back as the sampled input).
module rapcore_spi_controller #(
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
    parameter logic [7:0]  DIV_RESET = 8'd4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        SCK,
    output logic        CS,
    output logic        COPI,
    input  logic        CIPO,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_TAIL,
        S_GAP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  divCnt_q, divCnt_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic [31:0] txShift_q, txShift_d;
    logic [31:0] rxShift_q, rxShift_d;
    logic        csActive_q, csActive_d;

    logic [31:0] txData_q, txData_d;
    logic [31:0] rxData_q, rxData_d;
    logic        rxValid_q, rxValid_d;
    logic        rxOvr_q, rxOvr_d;
    logic        holdCs_q, holdCs_d;
    logic        ie_q, ie_d;
    logic [7:0]  div_q, div_d;

    logic        ack_q, ack_d;
    logic [31:0] datOut_q, datOut_d;

    logic        adrMatch, accValid, wrFull, rdEn;
    logic [1:0]  regSel;
    logic        ctrlWr, txWr, startReq, statusRd, rxRd;
    logic [31:0] rdData;
    logic [7:0]  divEff;
    logic        phaseEnd, busy, xferDone, loopbackEn, sampleBit;
    logic        unusedAdrBits;

    assign unusedAdrBits = ^wbs_adr_i[1:0];

    // A second access is not accepted while ack is high, so a held strobe yields a one-cycle pulse.
    assign adrMatch = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign accValid = wbs_stb_i & wbs_cyc_i & adrMatch & ~ack_q;
    assign regSel   = wbs_adr_i[3:2];
    assign wrFull   = accValid & wbs_we_i & (wbs_sel_i == 4'hF);
    assign rdEn     = accValid & ~wbs_we_i;
    assign ctrlWr   = wrFull & (regSel == 2'd0);
    assign txWr     = wrFull & (regSel == 2'd2);
    assign startReq = ctrlWr & wbs_dat_i[0];
    assign statusRd = rdEn & (regSel == 2'd1);
    assign rxRd     = rdEn & (regSel == 2'd3);

`ifdef RAPCORE_SPI_LOOPBACK_EN
    logic loopback_q, loopback_d;

    always_comb begin
        loopback_d = loopback_q;
        if (ctrlWr) begin
            loopback_d = wbs_dat_i[2];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            loopback_q <= 1'b0;
        end else begin
            loopback_q <= loopback_d;
        end
    end

    assign loopbackEn = loopback_q;
`else
    assign loopbackEn = 1'b0;
`endif

    assign divEff    = (div_q == 8'd0) ? 8'd1 : div_q;
    assign phaseEnd  = (divCnt_q >= (divEff - 8'd1));
    assign busy      = (state_q != S_IDLE);
    assign sampleBit = loopbackEn ? txShift_q[31] : CIPO;

    always_comb begin
        state_d    = state_q;
        divCnt_d   = divCnt_q;
        bitCnt_d   = bitCnt_q;
        txShift_d  = txShift_q;
        rxShift_d  = rxShift_q;
        csActive_d = csActive_q;
        xferDone   = 1'b0;

        if (state_q != S_IDLE) begin
            divCnt_d = phaseEnd ? 8'd0 : divCnt_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!holdCs_q) begin
                    csActive_d = 1'b0;
                end
                if (startReq) begin
                    state_d    = S_SETUP;
                    txShift_d  = txData_q;
                    rxShift_d  = '0;
                    csActive_d = 1'b1;
                    divCnt_d   = 8'd0;
                    bitCnt_d   = 5'd0;
                end
            end
            S_SETUP: begin
                if (phaseEnd) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (divCnt_q == 8'd0) begin
                    rxShift_d = {rxShift_q[30:0], sampleBit};
                end
                if (phaseEnd) begin
                    if (bitCnt_q == 5'd31) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d   = S_LOW;
                        bitCnt_d  = bitCnt_q + 5'd1;
                        txShift_d = {txShift_q[30:0], 1'b0};
                    end
                end
            end
            S_LOW: begin
                if (phaseEnd) begin
                    state_d = S_HIGH;
                end
            end
            S_TAIL: begin
                if (phaseEnd) begin
                    xferDone = 1'b1;
                    if (holdCs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_GAP;
                        csActive_d = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (phaseEnd) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                csActive_d = 1'b0;
            end
        endcase
    end

    // A completing transfer takes priority over the read-side clears of RX_VALID and RX_OVR.
    always_comb begin
        holdCs_d  = holdCs_q;
        ie_d      = ie_q;
        div_d     = div_q;
        txData_d  = txData_q;
        rxData_d  = rxData_q;
        rxValid_d = rxValid_q;
        rxOvr_d   = rxOvr_q;

        if (ctrlWr) begin
            holdCs_d = wbs_dat_i[1];
            ie_d     = wbs_dat_i[3];
            div_d    = wbs_dat_i[15:8];
        end
        if (txWr) begin
            txData_d = wbs_dat_i;
        end

        if (xferDone) begin
            rxData_d  = rxShift_q;
            rxValid_d = 1'b1;
        end else if (rxRd) begin
            rxValid_d = 1'b0;
        end

        if (xferDone && rxValid_q) begin
            rxOvr_d = 1'b1;
        end else if (statusRd) begin
            rxOvr_d = 1'b0;
        end
    end

    always_comb begin
        rdData = '0;
        unique case (regSel)
            2'd0:    rdData = {16'h0, div_q, 4'h0, ie_q, loopbackEn, holdCs_q, 1'b0};
            2'd1:    rdData = {28'h0, rxOvr_q, csActive_q, rxValid_q, busy};
            2'd2:    rdData = txData_q;
            default: rdData = rxData_q;
        endcase
        ack_d    = accValid;
        datOut_d = rdEn ? rdData : 32'h0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            divCnt_q   <= 8'd0;
            bitCnt_q   <= 5'd0;
            txShift_q  <= '0;
            rxShift_q  <= '0;
            csActive_q <= 1'b0;
            txData_q   <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            rxOvr_q    <= 1'b0;
            holdCs_q   <= 1'b0;
            ie_q       <= 1'b0;
            div_q      <= DIV_RESET;
            ack_q      <= 1'b0;
            datOut_q   <= '0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            bitCnt_q   <= bitCnt_d;
            txShift_q  <= txShift_d;
            rxShift_q  <= rxShift_d;
            csActive_q <= csActive_d;
            txData_q   <= txData_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            rxOvr_q    <= rxOvr_d;
            holdCs_q   <= holdCs_d;
            ie_q       <= ie_d;
            div_q      <= div_d;
            ack_q      <= ack_d;
            datOut_q   <= datOut_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = datOut_q;
    assign SCK       = (state_q == S_HIGH);
    assign CS        = ~csActive_q;
    assign COPI      = txShift_q[31];
    assign irq_o     = rxValid_q & ie_q;

endmodule
